// File: rtl/memoria_dual_leitura.sv
// Dual-read scratch RAM with byte-lane writes and a post-reset fill sequencer.
// One write port, two independent synchronous read ports (A, B), one-cycle latency.
module memoria_dual_leitura #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    BYTE_WIDTH  = 8,
  parameter bit                    WRITE_FIRST = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
  localparam int                   NB          = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  EscMen,
  input  logic [NB-1:0]         byte_en,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic                  LeMen_a,
  output logic [DATA_WIDTH-1:0] saida_a,
  output logic                  valido_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  input  logic                  LeMen_b,
  output logic [DATA_WIDTH-1:0] saida_b,
  output logic                  valido_b,
  output logic                  ocupado
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] next_counter;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;
  logic                  accept;
  logic                  read_en_a;
  logic                  read_en_b;
  logic                  collision_a;
  logic                  collision_b;
  logic [DATA_WIDTH-1:0] write_merged;

  assign ocupado = (state == INIT);

  // State and fill counter; reset always restarts the fill from word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= INIT;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // Next state and write-port steering: the fill owns the write port during INIT.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    mem_we       = 1'b0;
    mem_addr     = write_addr;
    mem_wdata    = data;
    mem_be       = byte_en;
    accept       = 1'b0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = counter;
        mem_wdata = INIT_VALUE;
        mem_be    = '1;
        if (counter == LAST_ADDR) begin
          next_state = READY;
        end else begin
          next_counter = counter + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        mem_we = EscMen && (|byte_en);
        accept = 1'b1;
      end
      default: begin
        next_state   = INIT;
        next_counter = '0;
      end
    endcase
  end

  // Word as it will look after this cycle's user write (used for write-first reads).
  always_comb begin
    write_merged = mem[write_addr];
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        write_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Per-port read acceptance and same-address collision detection.
  always_comb begin
    read_en_a   = accept && LeMen_a;
    read_en_b   = accept && LeMen_b;
    collision_a = EscMen && (write_addr == read_addr_a);
    collision_b = EscMen && (write_addr == read_addr_b);
  end

  // Storage array: byte-lane writes, suppressed on reset edges; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Port A read register: valid pulses one cycle after a strobe, data holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_a  <= '0;
      valido_a <= 1'b0;
    end else begin
      valido_a <= read_en_a;
      if (read_en_a) begin
        saida_a <= (WRITE_FIRST && collision_a) ? write_merged : mem[read_addr_a];
      end
    end
  end

  // Port B read register, identical to port A but fully independent.
  always_ff @(posedge clock) begin
    if (reset) begin
      saida_b  <= '0;
      valido_b <= 1'b0;
    end else begin
      valido_b <= read_en_b;
      if (read_en_b) begin
        saida_b <= (WRITE_FIRST && collision_b) ? write_merged : mem[read_addr_b];
      end
    end
  end

endmodule

// File: tb/tb_memoria_dual_leitura.sv
// Directed bench: two instances (read-first and write-first) driven in lockstep.
module tb_memoria_dual_leitura;

  logic        clock;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  write_addr;
  logic        EscMen;
  logic [1:0]  byte_en;
  logic [3:0]  read_addr_a;
  logic        LeMen_a;
  logic [3:0]  read_addr_b;
  logic        LeMen_b;

  logic [15:0] saida_a0, saida_b0, saida_a1, saida_b1;
  logic        valido_a0, valido_b0, valido_a1, valido_b1;
  logic        ocupado0, ocupado1;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [3:0]  waddr;
    logic        rda;
    logic [3:0]  ra;
    logic        rdb;
    logic [3:0]  rb;
    logic        va;
    logic [15:0] sa0;
    logic [15:0] sa1;
    logic        vb;
    logic [15:0] sb0;
    logic [15:0] sb1;
  } vec_t;

  vec_t vecs[$];

  memoria_dual_leitura #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .WRITE_FIRST(1'b0), .INIT_VALUE(16'hA5A5)
  ) dut0 (
    .clock(clock), .reset(reset), .data(data), .write_addr(write_addr),
    .EscMen(EscMen), .byte_en(byte_en),
    .read_addr_a(read_addr_a), .LeMen_a(LeMen_a), .saida_a(saida_a0), .valido_a(valido_a0),
    .read_addr_b(read_addr_b), .LeMen_b(LeMen_b), .saida_b(saida_b0), .valido_b(valido_b0),
    .ocupado(ocupado0)
  );

  memoria_dual_leitura #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .WRITE_FIRST(1'b1), .INIT_VALUE(16'hA5A5)
  ) dut1 (
    .clock(clock), .reset(reset), .data(data), .write_addr(write_addr),
    .EscMen(EscMen), .byte_en(byte_en),
    .read_addr_a(read_addr_a), .LeMen_a(LeMen_a), .saida_a(saida_a1), .valido_a(valido_a1),
    .read_addr_b(read_addr_b), .LeMen_b(LeMen_b), .saida_b(saida_b1), .valido_b(valido_b1),
    .ocupado(ocupado1)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input logic we, input logic [1:0] be, input logic [15:0] wd,
                             input logic [3:0] wa, input logic rda, input logic [3:0] ra,
                             input logic rdb, input logic [3:0] rb);
    EscMen = we; byte_en = be; data = wd; write_addr = wa;
    LeMen_a = rda; read_addr_a = ra; LeMen_b = rdb; read_addr_b = rb;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v.we, v.be, v.wdata, v.waddr, v.rda, v.ra, v.rdb, v.rb);
    tick();
    checkOutput({v.name, " ocupado"}, {15'd0, ocupado0 | ocupado1}, 16'd0);
    checkOutput({v.name, " valido_a wf0"}, {15'd0, valido_a0}, {15'd0, v.va});
    checkOutput({v.name, " valido_a wf1"}, {15'd0, valido_a1}, {15'd0, v.va});
    checkOutput({v.name, " saida_a wf0"}, saida_a0, v.sa0);
    checkOutput({v.name, " saida_a wf1"}, saida_a1, v.sa1);
    checkOutput({v.name, " valido_b wf0"}, {15'd0, valido_b0}, {15'd0, v.vb});
    checkOutput({v.name, " valido_b wf1"}, {15'd0, valido_b1}, {15'd0, v.vb});
    checkOutput({v.name, " saida_b wf0"}, saida_b0, v.sb0);
    checkOutput({v.name, " saida_b wf1"}, saida_b1, v.sb1);
  endtask

  // Runs INIT cycles with accesses asserted; returns edges until ocupado falls (0 on timeout).
  task automatic runInit(input string name, input int max_edges, output int edges);
    edges = 0;
    driveInputs(1'b1, 2'b11, 16'h1234, 4'd0, 1'b1, 4'd0, 1'b1, 4'd1);
    for (int i = 1; i <= max_edges; i++) begin
      tick();
      checkOutput({name, " valido during init"},
                  {14'd0, valido_a0 | valido_a1, valido_b0 | valido_b1}, 16'd0);
      checkOutput({name, " saida_a during init"}, saida_a0 | saida_a1, 16'd0);
      checkOutput({name, " saida_b during init"}, saida_b0 | saida_b1, 16'd0);
      if (!ocupado0 && !ocupado1) begin
        edges = i;
        break;
      end
    end
    driveInputs(1'b0, 2'b00, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " ocupado"}, {14'd0, ocupado0, ocupado1}, 16'h0003);
    checkOutput({name, " valido"}, {12'd0, valido_a0, valido_a1, valido_b0, valido_b1}, 16'd0);
    checkOutput({name, " saida_a"}, saida_a0 | saida_a1, 16'd0);
    checkOutput({name, " saida_b"}, saida_b0 | saida_b1, 16'd0);
  endtask

  initial begin
    int edges;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    driveInputs(1'b0, 2'b00, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

    // Reset state and full fill length
    tick();
    checkResetState("reset");
    reset = 1'b0;
    runInit("init", 40, edges);
    checkOutput("init length", 16'(edges), 16'd16);

    // Back-to-back reads of every word on port A
    for (int i = 0; i < 16; i++) begin
      driveInputs(1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'(i), 1'b0, 4'd0);
      tick();
      checkOutput($sformatf("fill valido_a %0d", i), {14'd0, valido_a0, valido_a1}, 16'h0003);
      checkOutput($sformatf("fill word %0d wf0", i), saida_a0, 16'hA5A5);
      checkOutput($sformatf("fill word %0d wf1", i), saida_a1, 16'hA5A5);
    end
    driveInputs(1'b0, 2'b00, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    checkOutput("fill valido_a drop", {14'd0, valido_a0, valido_a1}, 16'd0);
    checkOutput("fill saida_a hold", saida_a0 & saida_a1, 16'hA5A5);

    // name, we, be, wdata, waddr, rda, ra, rdb, rb, va, sa0, sa1, vb, sb0, sb1
    vecs.push_back('{"lo lane",      1'b1, 2'b01, 16'h1234, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{"hi lane",      1'b1, 2'b10, 16'hBEEF, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{"read merged",  1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 16'hBE34, 16'hBE34, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{"be none",      1'b1, 2'b00, 16'hFFFF, 4'd3, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 16'hBE34, 16'hBE34, 1'b1, 16'hBE34, 16'hBE34});
    vecs.push_back('{"be none rd",   1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 16'hBE34, 16'hBE34, 1'b0, 16'hBE34, 16'hBE34});
    vecs.push_back('{"wr 5",         1'b1, 2'b11, 16'h0055, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'hBE34, 16'hBE34, 1'b0, 16'hBE34, 16'hBE34});
    vecs.push_back('{"wr 6",         1'b1, 2'b11, 16'h0066, 4'd6, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'hBE34, 16'hBE34, 1'b0, 16'hBE34, 16'hBE34});
    vecs.push_back('{"dual read",    1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 16'h0055, 16'h0055, 1'b1, 16'h0066, 16'h0066});
    vecs.push_back('{"dual hold",    1'b0, 2'b00, 16'h0000, 4'd0, 1'b0, 4'd5, 1'b0, 4'd6, 1'b0, 16'h0055, 16'h0055, 1'b0, 16'h0066, 16'h0066});
    vecs.push_back('{"wr 2 1111",    1'b1, 2'b11, 16'h1111, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0055, 16'h0055, 1'b0, 16'h0066, 16'h0066});
    vecs.push_back('{"collide full", 1'b1, 2'b11, 16'h2222, 4'd2, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 16'h1111, 16'h2222, 1'b1, 16'h1111, 16'h2222});
    vecs.push_back('{"after coll",   1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 16'h2222, 16'h2222, 1'b1, 16'h2222, 16'h2222});
    vecs.push_back('{"rewr 1111",    1'b1, 2'b11, 16'h1111, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 16'h2222, 16'h2222, 1'b0, 16'h2222, 16'h2222});
    vecs.push_back('{"collide part", 1'b1, 2'b10, 16'hAB00, 4'd2, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 16'h1111, 16'hAB11, 1'b0, 16'h2222, 16'h2222});
    vecs.push_back('{"after part",   1'b0, 2'b00, 16'h0000, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 16'h1111, 16'hAB11, 1'b1, 16'hAB11, 16'hAB11});
    vecs.push_back('{"coll port b",  1'b1, 2'b01, 16'h00CC, 4'd7, 1'b1, 4'd8, 1'b1, 4'd7, 1'b1, 16'hA5A5, 16'hA5A5, 1'b1, 16'hA5A5, 16'hA5CC});
    vecs.push_back('{"after b",      1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 1'b1, 16'hA5CC, 16'hA5CC, 1'b0, 16'hA5A5, 16'hA5CC});

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset seven cycles into INIT, then a full fresh fill
    reset = 1'b1;
    tick();
    checkResetState("reset ready");
    reset = 1'b0;
    driveInputs(1'b1, 2'b11, 16'h1234, 4'd0, 1'b1, 4'd0, 1'b1, 4'd1);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("ocupado at cycle 7", {14'd0, ocupado0, ocupado1}, 16'h0003);
    reset = 1'b1;
    tick();
    checkResetState("reset mid init");
    reset = 1'b0;
    runInit("reinit", 40, edges);
    checkOutput("reinit length", 16'(edges), 16'd16);

    // Refill overwrote earlier data; writes during INIT were dropped
    driveInputs(1'b0, 2'b00, 16'h0000, 4'd0, 1'b1, 4'd0, 1'b1, 4'd5);
    tick();
    checkOutput("refill valid", {12'd0, valido_a0, valido_a1, valido_b0, valido_b1}, 16'h000F);
    checkOutput("refill addr0", saida_a0 & saida_a1, 16'hA5A5);
    checkOutput("refill addr0 or", saida_a0 | saida_a1, 16'hA5A5);
    checkOutput("refill addr5", saida_b0 & saida_b1, 16'hA5A5);
    checkOutput("refill addr5 or", saida_b0 | saida_b1, 16'hA5A5);

    // Reset in READY with a read still strobed
    reset = 1'b1;
    tick();
    checkResetState("reset pending read");
    reset = 1'b0;
    runInit("final init", 40, edges);
    checkOutput("final init length", 16'(edges), 16'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
